// File: rtl/mvm_cmd_ctrl_if.sv
// Byte-stream input, kx AXI-Stream output and status bundle of the MVM command sequencer.
// The controller takes the master view (it sources the kx beat); the bench takes the slave view.
interface mvm_cmd_ctrl_if #(
  parameter int TDATA_W = 576
);
  logic               s_byte_valid;
  logic [7:0]         s_byte_data;
  logic               m_axis_kx_tvalid;
  logic               m_axis_kx_tready;
  logic [TDATA_W-1:0] m_axis_kx_tdata;
  logic               busy;
  logic               k_loaded;
  logic               x_loaded;
  logic [3:0]         err_pulse;
  logic [7:0]         err_count;

  modport master (
    input  s_byte_valid, s_byte_data, m_axis_kx_tready,
    output m_axis_kx_tvalid, m_axis_kx_tdata,
    output busy, k_loaded, x_loaded, err_pulse, err_count
  );

  modport slave (
    output s_byte_valid, s_byte_data, m_axis_kx_tready,
    input  m_axis_kx_tvalid, m_axis_kx_tdata,
    input  busy, k_loaded, x_loaded, err_pulse, err_count
  );
endinterface

// File: rtl/mvm_cmd_ctrl.sv
// Opcode-framed byte parser that keeps matrix K resident and issues {X,K} beats to the
// matrix-vector multiplier, with overrun/timeout/protocol error pulses and a saturating count.
module mvm_cmd_ctrl #(
  parameter int R            = 8,
  parameter int C            = 8,
  parameter int W_K          = 8,
  parameter int W_X          = 8,
  parameter int TIMEOUT_CLKS = 2_000_000
) (
  input  logic          clk,
  input  logic          rst,
  mvm_cmd_ctrl_if.master kx_bus
);
  localparam int NK  = R * C;
  localparam int KW  = NK * W_K;
  localparam int XW  = C * W_X;
  localparam int IW  = (NK > 1) ? $clog2(NK) : 1;
  localparam int TCW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD_K, S_LOAD_X, S_ISSUE} state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_idx;
  logic [TCW-1:0]  r_tmo;
  logic [KW-1:0]   r_k;
  logic [XW-1:0]   r_x;
  logic            r_k_loaded, r_x_loaded;
  logic [3:0]      r_err;
  logic [7:0]      r_err_cnt;

  logic            w_byte;
  logic            w_in_load;
  logic            w_tmo_hit;
  logic            w_k_we, w_x_we, w_idx_clr;
  logic            w_k_clr, w_x_clr, w_k_set, w_x_set;
  logic [3:0]      w_err;

  assign w_byte    = kx_bus.s_byte_valid;
  assign w_in_load = (r_state == S_LOAD_K) || (r_state == S_LOAD_X);
  // Fires on the idle edge that would take the idle count to TIMEOUT_CLKS-1.
  assign w_tmo_hit = (r_tmo == TCW'(TIMEOUT_CLKS - 2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_k_we      = 1'b0;
    w_x_we      = 1'b0;
    w_idx_clr   = 1'b0;
    w_k_clr     = 1'b0;
    w_x_clr     = 1'b0;
    w_k_set     = 1'b0;
    w_x_set     = 1'b0;
    w_err       = 4'b0000;
    unique case (r_state)
      S_IDLE: begin
        if (w_byte) begin
          w_idx_clr = 1'b1;
          case (kx_bus.s_byte_data)
            8'h01: begin
              w_state_nxt = S_LOAD_K;
              w_k_clr     = 1'b1;
            end
            8'h02: begin
              w_state_nxt = S_LOAD_X;
              w_x_clr     = 1'b1;
            end
            8'h03: begin
              if (r_k_loaded && r_x_loaded) w_state_nxt = S_ISSUE;
              else                          w_err[1]    = 1'b1;
            end
            default: w_err[0] = 1'b1;
          endcase
        end
      end
      S_LOAD_K: begin
        if (w_byte) begin
          w_k_we = 1'b1;
          if (r_idx == IW'(NK - 1)) begin
            w_k_set     = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else if (w_tmo_hit) begin
          w_err[3]    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD_X: begin
        if (w_byte) begin
          w_x_we = 1'b1;
          if (r_idx == IW'(C - 1)) begin
            w_x_set = 1'b1;
            // X is kept even without K, but a beat is only legal with a resident K.
            if (r_k_loaded) w_state_nxt = S_ISSUE;
            else begin
              w_err[1]    = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
        end else if (w_tmo_hit) begin
          w_err[3]    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (w_byte) w_err[2] = 1'b1;
        if (kx_bus.m_axis_kx_tready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx      <= '0;
      r_tmo      <= '0;
      r_k        <= '0;
      r_x        <= '0;
      r_k_loaded <= 1'b0;
      r_x_loaded <= 1'b0;
      r_err      <= 4'b0000;
      r_err_cnt  <= 8'd0;
    end else begin
      if (w_idx_clr)                r_idx <= '0;
      else if (w_k_we || w_x_we)    r_idx <= r_idx + IW'(1);

      if (w_in_load && !w_byte && !w_tmo_hit) r_tmo <= r_tmo + TCW'(1);
      else                                    r_tmo <= '0;

      if (w_k_we) r_k[int'(r_idx)*W_K +: W_K] <= kx_bus.s_byte_data;
      if (w_x_we) r_x[int'(r_idx)*W_X +: W_X] <= kx_bus.s_byte_data;

      if (w_k_clr)      r_k_loaded <= 1'b0;
      else if (w_k_set) r_k_loaded <= 1'b1;
      if (w_x_clr)      r_x_loaded <= 1'b0;
      else if (w_x_set) r_x_loaded <= 1'b1;

      r_err <= w_err;
      if ((|w_err) && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign kx_bus.m_axis_kx_tvalid = (r_state == S_ISSUE);
  assign kx_bus.m_axis_kx_tdata  = {r_x, r_k};
  assign kx_bus.busy             = (r_state != S_IDLE);
  assign kx_bus.k_loaded         = r_k_loaded;
  assign kx_bus.x_loaded         = r_x_loaded;
  assign kx_bus.err_pulse        = r_err;
  assign kx_bus.err_count        = r_err_cnt;

endmodule

// File: tb/tb_mvm_cmd_ctrl.sv
// Self-checking bench for mvm_cmd_ctrl: directed scenarios plus randomized byte traffic,
// compared every cycle against a frame-level reference model.
module tb_mvm_cmd_ctrl;
  localparam int R   = 8;
  localparam int C   = 8;
  localparam int NK  = R * C;
  localparam int TW  = NK * 8 + C * 8;
  localparam int TMO = 16;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;
  int   n_xfer;

  mvm_cmd_ctrl_if #(.TDATA_W(TW)) bus ();

  mvm_cmd_ctrl #(
    .R(R), .C(C), .W_K(8), .W_X(8), .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .kx_bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: frame mode (0 idle, 1 loading K, 2 loading X, 3 beat pending),
  // byte arrays for K and X, and idle cycles since the last byte.
  int          m_mode;
  int          m_pos;
  int          m_idle;
  int          m_e;
  logic [7:0]  mk [NK];
  logic [7:0]  mx [C];
  bit          m_kl, m_xl;
  logic [3:0]  m_err;
  int          m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_pos = 0; m_idle = 0; m_kl = 0; m_xl = 0; m_err = 4'b0; m_cnt = 0;
      for (int i = 0; i < NK; i++) mk[i] = 8'h00;
      for (int i = 0; i < C; i++)  mx[i] = 8'h00;
    end else begin
      m_e = -1;
      if (m_mode == 3) begin
        if (bus.s_byte_valid) m_e = 2;
        if (bus.m_axis_kx_tready) m_mode = 0;
      end else if (bus.s_byte_valid) begin
        m_idle = 0;
        if (m_mode == 0) begin
          if (bus.s_byte_data == 8'h01) begin m_mode = 1; m_pos = 0; m_kl = 0; end
          else if (bus.s_byte_data == 8'h02) begin m_mode = 2; m_pos = 0; m_xl = 0; end
          else if (bus.s_byte_data == 8'h03) begin
            if (m_kl && m_xl) m_mode = 3; else m_e = 1;
          end else m_e = 0;
        end else if (m_mode == 1) begin
          mk[m_pos] = bus.s_byte_data;
          m_pos++;
          if (m_pos == NK) begin m_kl = 1; m_mode = 0; end
        end else begin
          mx[m_pos] = bus.s_byte_data;
          m_pos++;
          if (m_pos == C) begin
            m_xl = 1;
            if (m_kl) m_mode = 3; else begin m_mode = 0; m_e = 1; end
          end
        end
      end else if (m_mode == 1 || m_mode == 2) begin
        m_idle++;
        if (m_idle == TMO - 1) begin m_e = 3; m_mode = 0; end
      end
      m_err = (m_e >= 0) ? 4'(1 << m_e) : 4'b0000;
      if (m_e >= 0 && m_cnt < 255) m_cnt++;
    end
  end

  function automatic logic [TW-1:0] model_tdata();
    logic [TW-1:0] v;
    v = '0;
    for (int n = 0; n < NK; n++) v[8*n +: 8] = mk[n];
    for (int c = 0; c < C; c++)  v[NK*8 + 8*c +: 8] = mx[c];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("tvalid",    bus.m_axis_kx_tvalid, m_mode == 3);
      chk("busy",      bus.busy, m_mode != 0);
      chk("k_loaded",  bus.k_loaded, m_kl);
      chk("x_loaded",  bus.x_loaded, m_xl);
      chk("err_pulse", bus.err_pulse, m_err);
      chk("err_count", bus.err_count, m_cnt);
      if (m_mode == 3) begin
        n_chk++;
        if (bus.m_axis_kx_tdata !== model_tdata()) begin
          n_err++;
          $display("FAIL tdata actual=%0h required=%0h", bus.m_axis_kx_tdata, model_tdata());
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && bus.m_axis_kx_tvalid && bus.m_axis_kx_tready) n_xfer++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.s_byte_valid = 1'b1;
    bus.s_byte_data  = b;
    tick();
    bus.s_byte_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [TW-1:0] exp_kx;
  int            got;
  int            xfer0;

  initial begin
    n_chk = 0; n_err = 0; n_xfer = 0;
    rst = 1'b1;
    bus.s_byte_valid = 1'b0;
    bus.s_byte_data  = 8'h00;
    bus.m_axis_kx_tready = 1'b0;
    tick(); tick();
    chk("rst_tvalid", bus.m_axis_kx_tvalid, 1'b0);
    chk("rst_busy",   bus.busy, 1'b0);
    chk("rst_errcnt", bus.err_count, 8'd0);
    n_chk++;
    if (bus.m_axis_kx_tdata !== '0) begin
      n_err++;
      $display("FAIL rst_tdata actual=%0h required=0", bus.m_axis_kx_tdata);
    end
    rst = 1'b0;
    tick();

    // Load K = 0x00..0x3F
    send_byte(8'h01);
    for (int n = 0; n < NK; n++) send_byte(8'(n));
    chk("k_loaded_after_k", bus.k_loaded, 1'b1);
    chk("no_tvalid_after_k", bus.m_axis_kx_tvalid, 1'b0);
    chk("k_byte0",  bus.m_axis_kx_tdata[7:0], 8'h00);
    chk("k_byte63", bus.m_axis_kx_tdata[511:504], 8'h3F);

    // Load X = 0xF8..0xFF and run with tready high
    bus.m_axis_kx_tready = 1'b1;
    send_byte(8'h02);
    for (int c = 0; c < C; c++) send_byte(8'hF8 + 8'(c));
    chk("tvalid_at_last_plus1", bus.m_axis_kx_tvalid, 1'b1);
    chk("x_byte0", bus.m_axis_kx_tdata[519:512], 8'hF8);
    chk("x_byte7", bus.m_axis_kx_tdata[575:568], 8'hFF);
    chk("k_kept",  bus.m_axis_kx_tdata[511:504], 8'h3F);
    tick();
    chk("tvalid_one_cycle", bus.m_axis_kx_tvalid, 1'b0);
    chk("xfer_count_1", n_xfer, 1);

    // RUN with back-pressure and two overrun bytes
    for (int n = 0; n < NK; n++) exp_kx[8*n +: 8] = 8'(n);
    for (int c = 0; c < C; c++)  exp_kx[NK*8 + 8*c +: 8] = 8'hF8 + 8'(c);
    bus.m_axis_kx_tready = 1'b0;
    send_byte(8'h03);
    for (int i = 0; i < 20; i++) begin
      if (i == 5 || i == 12) begin
        send_byte(8'($urandom_range(0, 255)));
        chk("overrun_pulse", bus.err_pulse, 4'b0100);
      end else tick();
    end
    chk("overrun_count", bus.err_count, 8'd2);
    n_chk++;
    if (bus.m_axis_kx_tdata !== exp_kx) begin
      n_err++;
      $display("FAIL held_tdata actual=%0h required=%0h", bus.m_axis_kx_tdata, exp_kx);
    end
    chk("xfer_before_ready", n_xfer, 1);
    bus.m_axis_kx_tready = 1'b1;
    tick();
    chk("tvalid_after_ready", bus.m_axis_kx_tvalid, 1'b0);
    chk("xfer_count_2", n_xfer, 2);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      bus.m_axis_kx_tready = ($urandom_range(0, 3) != 0);
      if (r < 5) begin
        for (int g = 0; g < 18; g++) tick();
      end else if (r < 450) begin
        if (r < 60)       send_byte(8'h01);
        else if (r < 110) send_byte(8'h02);
        else if (r < 150) send_byte(8'h03);
        else              send_byte(8'($urandom_range(0, 255)));
      end else tick();
    end
    bus.m_axis_kx_tready = 1'b0;

    // RUN without K/X, then a bad opcode
    do_reset();
    xfer0 = n_xfer;
    send_byte(8'h03);
    chk("run_no_kx_pulse", bus.err_pulse, 4'b0010);
    send_byte(8'h7E);
    chk("bad_op_pulse", bus.err_pulse, 4'b0001);
    chk("two_errors", bus.err_count, 8'd2);
    chk("no_tvalid_on_errors", bus.m_axis_kx_tvalid, 1'b0);
    chk("no_xfer_on_errors", n_xfer, xfer0);

    // Timeout after 5 bytes
    send_byte(8'h01);
    for (int n = 0; n < 5; n++) send_byte(8'h10 + 8'(n));
    got = -1;
    for (int k = 1; k <= 40 && got < 0; k++) begin
      tick();
      if (bus.err_pulse[3]) got = k;
    end
    chk("timeout_latency", got, 15);
    chk("timeout_k_loaded", bus.k_loaded, 1'b0);
    chk("timeout_busy", bus.busy, 1'b0);

    // Byte on the terminal-count cycle keeps the frame alive
    send_byte(8'h01);
    for (int n = 0; n < 5; n++) send_byte(8'h20 + 8'(n));
    for (int k = 0; k < 14; k++) tick();
    send_byte(8'h25);
    chk("terminal_byte_busy", bus.busy, 1'b1);
    chk("terminal_byte_nopulse", bus.err_pulse, 4'b0000);
    for (int n = 6; n < NK; n++) send_byte(8'h20 + 8'(n));
    chk("terminal_frame_done", bus.k_loaded, 1'b1);

    // Saturating error counter
    do_reset();
    for (int i = 0; i < 300; i++) send_byte(8'h7E);
    chk("err_count_sat", bus.err_count, 8'd255);

    // Asynchronous reset in the middle of LOAD_K
    send_byte(8'h01);
    for (int n = 0; n < 10; n++) send_byte(8'h55);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_busy",   bus.busy, 1'b0);
    chk("async_errcnt", bus.err_count, 8'd0);
    chk("async_status", {bus.m_axis_kx_tvalid, bus.k_loaded, bus.x_loaded, bus.err_pulse}, 7'd0);
    n_chk++;
    if (bus.m_axis_kx_tdata !== '0) begin
      n_err++;
      $display("FAIL async_tdata actual=%0h required=0", bus.m_axis_kx_tdata);
    end
    tick();
    rst = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mvm_cmd_ctrl.md
Name: mvm_cmd_ctrl

Overview:
- Command sequencer between the UART RX byte stream and the AXI-Stream matrix-vector multiplier's kx input.
- Parses opcode-framed byte packets and holds the matrix K resident on chip, so each new compute only needs the C-byte vector X (or nothing, for a re-run).
- Assembles the full {X,K} beat and issues it with a valid/ready handshake.
- Reports protocol errors through per-cycle pulses and a saturating error counter.

Parameters:
- R, 8, matrix rows.
- C, 8, matrix columns / vector length.
- W_K, 8, K element width; must equal 8 (one byte per element).
- W_X, 8, X element width; must equal 8 (one byte per element).
- TIMEOUT_CLKS, 2_000_000, maximum idle cycles between bytes inside a frame before the frame is aborted.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- s_byte_valid  in  1  single-cycle strobe: received byte present.
- s_byte_data  in  8  received byte.
- m_axis_kx_tvalid  out  1  kx beat valid.
- m_axis_kx_tready  in  1  multiplier ready.
- m_axis_kx_tdata  out  R*C*W_K+C*W_X  bits {X,K}: K in the low R*C*8 bits, X in the upper C*8 bits.
- busy  out  1  high in any state other than IDLE.
- k_loaded  out  1  a complete K is held.
- x_loaded  out  1  a complete X is held.
- err_pulse  out  4  one-cycle pulses: [0] bad opcode, [1] run without K/X, [2] overrun, [3] timeout.
- err_count  out  8  saturating count of error events.

Behaviour:
- Reset: async on rst high.
  - State forced to IDLE; K and X registers cleared.
  - All outputs 0: tvalid, busy, k_loaded, x_loaded, err_pulse, err_count, tdata.
- Opcodes (first byte in IDLE):
  - 0x01 LOAD_K: followed by R*C bytes.
  - 0x02 LOAD_X_RUN: followed by C bytes, then issues a beat.
  - 0x03 RUN: issues a beat from the stored K and X.
  - Any other value: err_pulse[0], stay in IDLE.
- Packing:
  - K byte n (n=0..R*C-1, row-major, n=r*C+c) goes to tdata[8n+7:8n].
  - X byte c goes to tdata[R*C*8+8c+7 : R*C*8+8c].
  - Elements are signed two's complement; the controller passes them through unmodified.
- States: IDLE, LOAD_K, LOAD_X, ISSUE.
  - IDLE + 0x01: go to LOAD_K; k_loaded cleared the next cycle; byte index cleared.
  - IDLE + 0x02: go to LOAD_X; x_loaded cleared; index cleared.
  - IDLE + 0x03:
    - If k_loaded and x_loaded: go to ISSUE.
    - Otherwise: err_pulse[1], stay in IDLE.
  - LOAD_K: each byte is written to K[index] and index increments.
    - On byte R*C-1: k_loaded=1, return to IDLE.
  - LOAD_X: each byte is written to X[index].
    - On byte C-1: x_loaded=1, go to ISSUE.
    - This path needs k_loaded at the time of the 0x02 opcode; otherwise the bytes are still absorbed into X and err_pulse[1] fires on completion instead of entering ISSUE.
  - ISSUE: tvalid=1 with tdata stable.
    - On tvalid&&tready, go to IDLE; tvalid low the next cycle.
    - K, X, k_loaded and x_loaded are retained, so RUN can re-issue.
- Latency: final payload byte or RUN opcode accepted at cycle t gives tvalid=1 at t+1.
- Overrun: any s_byte_valid while in ISSUE, including the handshake cycle, is dropped and raises err_pulse[2].
- Timeout:
  - A cycle counter runs only in LOAD_K/LOAD_X and resets on each byte.
  - When it reaches TIMEOUT_CLKS-1 with no byte: err_pulse[3], return to IDLE.
  - The partial frame's loaded flag stays 0; register contents are don't-care.
  - A byte arriving on the terminal count cycle wins: it is accepted and the counter resets.
- err_count increments by 1 on any err_pulse bit set and saturates at 255. At most one error bit can be set per cycle.
- Reset mid-frame or mid-ISSUE: immediate return to reset state; a pending beat is abandoned with tvalid low.
- busy = (state != IDLE).

Test Plan:
- Reset, then 0x01 followed by bytes 0x00..0x3F -> k_loaded=1 one cycle after the last byte; tdata[7:0]=0x00, tdata[511:504]=0x3F; no tvalid.
- Then 0x02 followed by bytes 0xF8..0xFF with tready=1 -> tvalid high for exactly 1 cycle, at last byte+1; tdata[519:512]=0xF8, tdata[575:568]=0xFF; K field unchanged.
- Hold tready=0 for 20 cycles after 0x03, sending 2 bytes during that window -> tdata stable, err_pulse[2] twice, err_count=2; single transfer when tready rises.
- After reset, send 0x03, then 0x7E -> err_pulse[1], then err_pulse[0]; err_count=2; tvalid never asserted.
- With TIMEOUT_CLKS=16: send 0x01 plus 5 bytes, then idle -> err_pulse[3] 15 cycles after the 5th byte, k_loaded=0, busy=0. A byte arriving exactly on cycle 15 instead continues the frame.
- Send 300 bad opcodes -> err_count saturates at 255. Assert rst mid-LOAD_K -> all outputs 0 asynchronously.
